// File: rtl/bf_acc_drain.sv
// ---------------------------------------------------------------------------
// bf_acc_drain
//   Output-side drain for the bfloat16 MAC array. Takes the fp32 accumulator
//   results streamed out of the PEs, rounds each one to bf16 with
//   round-to-nearest-even, optionally clamps negative values to zero (ReLU),
//   and packs two bf16 values into each 32-bit word for the output DMA.
//
//   Parameters
//     RELU_EN    1: every non-NaN negative result (including -inf) -> 0x0000
//
//   Ports
//     clk        clock, rising edge
//     rst        asynchronous reset, active low
//     in_valid   in_data / in_last valid
//     in_ready   block accepts an input element this cycle
//     in_data    fp32 accumulator value
//     in_last    final element of a result vector
//     out_valid  out_data / out_last valid
//     out_ready  downstream accepts the output word
//     out_data   packed word: [15:0] earlier element, [31:16] later element
//     out_last   word holds the last element of a vector
//     nan_cnt    saturating count of accepted NaN inputs
//     busy       an element or word is still held somewhere in the block
// ---------------------------------------------------------------------------
module bf_acc_drain #(
    parameter bit RELU_EN = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic [15:0] nan_cnt,
    output logic        busy
);

    typedef enum logic {
        EMPTY = 1'b0,
        HALF  = 1'b1
    } pack_state_t;

    pack_state_t pack_state;
    pack_state_t pack_next;

    // fp32 -> bf16 conversion of the incoming element
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [22:0] in_man;
    logic        in_nan;
    logic        round_up;
    logic [14:0] rounded;
    logic [15:0] conv;

    always_comb begin
        in_sign  = in_data[31];
        in_exp   = in_data[30:23];
        in_man   = in_data[22:0];
        in_nan   = (in_exp == 8'hFF) && (in_man != '0);
        round_up = in_man[15] & ((|in_man[14:0]) | in_man[16]);
        // Exponent and upper mantissa are added as one field so a rounding
        // carry ripples into the exponent; 0xFE/0x7F + 1 lands exactly on inf.
        rounded  = {in_exp, in_man[22:16]} + {14'd0, round_up};

        if (in_nan)
            conv = 16'h7FC0;
        else if (in_exp == 8'hFF)
            conv = {in_sign, 8'hFF, 7'd0};
        else if (in_exp == '0)
            conv = {in_sign, 15'd0};
        else
            conv = {in_sign, rounded};

        if (RELU_EN && conv[15] && !in_nan)
            conv = '0;
    end

    // Handshake and flow control
    logic        s1_valid;
    logic        s1_last;
    logic [15:0] s1_data;
    logic [15:0] low;
    logic        in_fire;
    logic        out_free;
    logic        s1_take;
    logic        word_load;
    logic        word_last;
    logic [31:0] word_data;
    logic        low_load;

    assign in_fire  = in_valid & in_ready;
    assign out_free = ~out_valid | out_ready;
    // A non-last element arriving in EMPTY only fills `low`, so it may move
    // even while the output register is blocked.
    assign s1_take  = s1_valid & (((pack_state == EMPTY) & ~s1_last) | out_free);
    assign in_ready = rst & (~s1_valid | s1_take);
    assign busy     = s1_valid | (pack_state == HALF) | out_valid;

    // Stage 1 register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_last  <= 1'b0;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            s1_data  <= conv;
            s1_last  <= in_last;
        end else if (s1_take) begin
            s1_valid <= 1'b0;
        end
    end

    // NaN counter, updated at the input handshake
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            nan_cnt <= '0;
        else if (in_fire && in_nan && (nan_cnt != '1))
            nan_cnt <= nan_cnt + 16'd1;
    end

    // Packer FSM: state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            pack_state <= EMPTY;
        else
            pack_state <= pack_next;
    end

    // Packer FSM: next state
    always_comb begin
        pack_next = pack_state;
        if (s1_take) begin
            case (pack_state)
                EMPTY:   if (!s1_last) pack_next = HALF;
                HALF:    pack_next = EMPTY;
                default: pack_next = EMPTY;
            endcase
        end
    end

    // Packer FSM: outputs
    always_comb begin
        word_load = 1'b0;
        word_data = '0;
        word_last = 1'b0;
        low_load  = 1'b0;
        if (s1_take) begin
            case (pack_state)
                EMPTY: begin
                    if (s1_last) begin
                        word_load = 1'b1;
                        word_data = {16'h0000, s1_data};
                        word_last = 1'b1;
                    end else begin
                        low_load = 1'b1;
                    end
                end
                HALF: begin
                    word_load = 1'b1;
                    word_data = {s1_data, low};
                    word_last = s1_last;
                end
                default: begin
                    word_load = 1'b0;
                end
            endcase
        end
    end

    // Low-half holding register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            low <= '0;
        else if (low_load)
            low <= s1_data;
    end

    // Output register; data only changes when a new word is loaded
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (word_load) begin
            out_valid <= 1'b1;
            out_data  <= word_data;
            out_last  <= word_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bf_acc_drain.sv
// ---------------------------------------------------------------------------
// tb_bf_acc_drain
//   Scoreboard bench for bf_acc_drain. Two instances (RELU_EN=0 and 1) share
//   the same input stream and out_ready; flow control does not depend on the
//   data, so both move in lockstep. Expected words come from a reference
//   rounding model working on the fp32 value as integer fields.
// ---------------------------------------------------------------------------
module tb_bf_acc_drain;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid;
    logic        in_last;
    logic [31:0] in_data;
    logic        out_ready;

    logic        in_ready0, in_ready1;
    logic        out_valid0, out_valid1;
    logic        out_last0, out_last1;
    logic [31:0] out_data0, out_data1;
    logic [15:0] nan_cnt0, nan_cnt1;
    logic        busy0, busy1;

    bf_acc_drain #(.RELU_EN(1'b0)) dut0 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0), .out_last(out_last0),
        .nan_cnt(nan_cnt0), .busy(busy0)
    );

    bf_acc_drain #(.RELU_EN(1'b1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1), .out_last(out_last1),
        .nan_cnt(nan_cnt1), .busy(busy1)
    );

    int          checks = 0;
    int          errors = 0;
    logic [32:0] q0[$];
    logic [32:0] q1[$];
    logic        pend_v;
    logic [15:0] pend0, pend1;
    logic [15:0] exp_nan;
    int          or_mode;
    logic [31:0] cyc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference rounding: treat the top 16 bits as the candidate result and
    // the bottom 16 bits as the discarded fraction.
    function automatic logic [15:0] ref_bf16(input logic [31:0] x, input bit relu);
        int unsigned mag;
        int unsigned frac;
        logic [14:0] m15;
        if (x[30:23] == 8'hFF && x[22:0] != 23'd0) return 16'h7FC0;
        mag  = {17'd0, x[30:16]};
        frac = {16'd0, x[15:0]};
        if (x[30:23] == 8'd0)
            mag = 0;
        else if (x[30:23] != 8'hFF && (frac > 32768 || (frac == 32768 && (mag % 2) == 1)))
            mag = mag + 1;
        if (relu && x[31]) return 16'h0000;
        m15 = mag[14:0];
        return {x[31], m15};
    endfunction

    task automatic model_push(input logic [31:0] d, input logic l);
        logic [15:0] a0, a1;
        a0 = ref_bf16(d, 1'b0);
        a1 = ref_bf16(d, 1'b1);
        if (d[30:23] == 8'hFF && d[22:0] != 23'd0 && exp_nan != 16'hFFFF)
            exp_nan = exp_nan + 16'd1;
        if (!pend_v) begin
            if (l) begin
                q0.push_back({1'b1, 16'h0000, a0});
                q1.push_back({1'b1, 16'h0000, a1});
            end else begin
                pend_v = 1'b1;
                pend0  = a0;
                pend1  = a1;
            end
        end else begin
            q0.push_back({l, a0, pend0});
            q1.push_back({l, a1, pend1});
            pend_v = 1'b0;
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the accept.
    task automatic send(input logic [31:0] d, input logic l);
        int n;
        bit done;
        n    = 0;
        done = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!done) begin
            #2;
            check("ready_match", 64'(in_ready1), 64'(in_ready0));
            if (in_ready0) begin
                model_push(d, l);
                done = 1;
            end else if (n > 300) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: got in_ready=0 for %0d cycles expected acceptance", n);
                done = 1;
            end
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int unsigned n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q0.size() != 0 || busy0 || busy1) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 1000) begin
            errors++;
            $display("FAIL drain_timeout: got %0d words outstanding expected 0", q0.size());
        end
        check("nan_cnt0", 64'(nan_cnt0), 64'(exp_nan));
        check("nan_cnt1", 64'(nan_cnt1), 64'(exp_nan));
    endtask

    function automatic logic [31:0] rand_val();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 7))
            0: rand_val = {r[31], 8'hFF, 23'($urandom_range(1, 23'h7FFFFF))};
            1: rand_val = {r[31], 8'hFF, 23'd0};
            2: rand_val = {r[31], 8'h00, r[22:0]};
            3: rand_val = {r[31:16] | 32'h0080_0000 >> 16, 16'h8000};
            4: rand_val = {r[31], 15'h7F7F, r[15:0]};
            default: rand_val = r;
        endcase
    endfunction

    // out_ready generator: 0 always 1, 1 pattern 1,0,0,1, 2 mostly 1, 3 always 0, 4 50%
    initial begin
        logic [3:0] pat;
        pat       = 4'b1001;
        out_ready = 1'b1;
        cyc       = '0;
        forever begin
            @(negedge clk);
            cyc = cyc + 32'd1;
            case (or_mode)
                1:       out_ready = pat[cyc[1:0]];
                2:       out_ready = ($urandom_range(0, 3) != 0);
                3:       out_ready = 1'b0;
                4:       out_ready = ($urandom_range(0, 1) != 0);
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Monitor: pops the scoreboard on each output handshake and checks that a
    // stalled word stays put.
    initial begin
        logic        stall;
        logic [32:0] held0, held1, e;
        stall = 1'b0;
        held0 = '0;
        held1 = '0;
        forever begin
            @(negedge clk);
            #3;
            if (!rst) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    check("stall_valid", 64'(out_valid0), 64'd1);
                    check("stall_hold0", 64'({out_last0, out_data0}), 64'(held0));
                    check("stall_hold1", 64'({out_last1, out_data1}), 64'(held1));
                end
                if (out_valid1 !== out_valid0)
                    check("valid_match", 64'(out_valid1), 64'(out_valid0));
                if (out_valid0 && out_ready) begin
                    if (q0.size() == 0 || q1.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_word: got %h expected no word", {out_last0, out_data0});
                    end else begin
                        e = q0.pop_front();
                        check("word0", 64'({out_last0, out_data0}), 64'(e));
                        e = q1.pop_front();
                        check("word1", 64'({out_last1, out_data1}), 64'(e));
                    end
                end
                stall = out_valid0 && !out_ready;
                held0 = {out_last0, out_data0};
                held1 = {out_last1, out_data1};
            end
        end
    end

    initial begin
        #3000000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        logic [31:0] d;
        logic        l;
        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        or_mode  = 0;
        pend_v   = 1'b0;
        pend0    = '0;
        pend1    = '0;
        exp_nan  = '0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid0), 64'd0);
        check("rst_out_data", 64'(out_data0), 64'd0);
        check("rst_out_last", 64'(out_last0), 64'd0);
        check("rst_busy", 64'(busy0), 64'd0);
        check("rst_in_ready", 64'(in_ready0), 64'd0);
        check("rst_nan_cnt", 64'(nan_cnt0), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rel_in_ready", 64'(in_ready0), 64'd1);
        @(negedge clk);

        // Basic pair with latency
        send(32'h3F800000, 1'b0);
        send(32'h40490FDB, 1'b1);
        #1 check("lat_pair_early", 64'(out_valid0), 64'd0);
        @(negedge clk);
        #1 check("lat_pair_valid", 64'(out_valid0), 64'd1);
        @(negedge clk);
        drain();

        // Ties and sticky
        send(32'h3F808000, 1'b0);
        send(32'h3F818000, 1'b1);
        send(32'h3F808001, 1'b1);
        drain();

        // Rounding overflow to inf, canonical NaN
        send(32'h7F7FFFFF, 1'b0);
        send(32'hFFC00001, 1'b1);
        drain();

        // Denormal flush with odd-length latency, then ReLU cases
        send(32'h00400000, 1'b1);
        #1 check("lat_odd_early", 64'(out_valid0), 64'd0);
        @(negedge clk);
        #1 check("lat_odd_valid", 64'(out_valid0), 64'd1);
        @(negedge clk);
        send(32'hC0000000, 1'b0);
        send(32'hFF800000, 1'b1);
        drain();

        // 8-element vector under a 1,0,0,1 out_ready pattern
        or_mode = 1;
        for (int i = 0; i < 8; i++)
            send(32'h3F800000 + (32'(i) << 16), (i == 7));
        drain();

        // Full backpressure: four elements fill the pipeline, then in_ready drops
        or_mode = 3;
        @(negedge clk);
        for (int i = 0; i < 4; i++)
            send(32'h40000000 + (32'(i) << 16), 1'b0);
        #1 check("bp_in_ready", 64'(in_ready0), 64'd0);
        @(negedge clk);
        #1 check("bp_in_ready_hold", 64'(in_ready0), 64'd0);
        @(negedge clk);
        or_mode = 0;
        send(32'h41000000, 1'b1);
        drain();

        // Reset while HALF with a word pending
        or_mode = 3;
        @(negedge clk);
        send(32'h3F800000, 1'b0);
        send(32'h40000000, 1'b1);
        send(32'h40400000, 1'b0);
        @(negedge clk);
        #1 check("pre_rst_valid", 64'(out_valid0), 64'd1);
        #1 rst = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(out_valid0), 64'd0);
        check("mid_rst_out_data", 64'(out_data0), 64'd0);
        check("mid_rst_out_last", 64'(out_last0), 64'd0);
        check("mid_rst_busy", 64'(busy0), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready0), 64'd0);
        check("mid_rst_nan_cnt", 64'(nan_cnt0), 64'd0);
        check("mid_rst_out_data1", 64'(out_data1), 64'd0);
        q0.delete();
        q1.delete();
        pend_v  = 1'b0;
        exp_nan = '0;
        @(negedge clk);
        rst     = 1'b1;
        or_mode = 0;
        #1 check("rel2_in_ready", 64'(in_ready0), 64'd1);
        @(negedge clk);
        send(32'h40000000, 1'b0);
        send(32'h40400000, 1'b1);
        drain();

        // Randomized streams under different out_ready behaviour
        for (int ph = 0; ph < 3; ph++) begin
            or_mode = (ph == 0) ? 2 : (ph == 1) ? 4 : 1;
            for (int i = 0; i < 300; i++) begin
                d = rand_val();
                l = ($urandom_range(0, 4) == 0) || (i == 299);
                send(d, l);
                if ($urandom_range(0, 3) == 0)
                    idle($urandom_range(1, 3));
            end
            drain();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
